load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Byte-addressed RV32 load/store front end for data_mem (32-bit word-indexed,
//  1-cycle registered read, no byte enables). Converts core requests (byte
//  address, funct3 size/sign) into word accesses. Loads are sign/zero-extended.
//  SB/SH use read-modify-write. Sits between the execute stage and data_mem.
// PARAMETERS
//  MEM_WORDS  4096  data_mem depth in 32-bit words (used only by bounds check)
// PORTS
//  clk             in   1   clock; all state on posedge
//  rst_n           in   1   reset, asynchronous, active-low
//  req_valid       in   1   core request present
//  req_ready       out  1   LSU can accept (high only in IDLE)
//  req_we          in   1   1=store, 0=load
//  req_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data (B/H use low bits)
//  resp_valid      out  1   one-cycle pulse: load data / store ack / error
//  resp_rdata      out  32  extended load data; 0 for stores and errors
//  resp_err        out  1   misaligned, illegal funct3, or out-of-range
//  mem_write_en    out  1   to data_mem.write_en
//  mem_addr        out  32  word index = {2'b00, addr_q[31:2]}
//  mem_write_data  out  32  to data_mem.write_data
//  mem_read_data   in   32  from data_mem.read_data (valid 1 cycle after addr)
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, addr/data/funct3
//   regs=0. mem_write_en decodes from state, so it is 0 as soon as rst_n falls.
//   Reset mid-operation aborts: no write issued, no response.
//  States: IDLE, ISSUE, MERGE, CAPTURE, RESP. Accept = req_valid&&req_ready at
//   edge N; req_addr/we/funct3/wdata are latched. No backpressure on resp.
//  Error check at accept: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0;
//   funct3 011/110/111; store funct3 not 000/001/010 -> RESP, err=1.
//   resp_valid is high in cycle N+1. No memory access.
//  LOAD: IDLE->ISSUE (mem_addr driven, we=0). After edge N+1 -> CAPTURE
//   (mem_read_data valid). Lane select by addr_q[1:0] (little-endian).
//   B/BU use byte [8k+7:8k]; H/HU use half [16h+15:16h]; sign- or zero-extend.
//   Result and resp_valid are registered at edge N+2, so resp is in cycle N+3.
//  SW: ISSUE drives mem_write_en=1, mem_write_data=wdata_q; write at edge N+1.
//   RESP follows, so the ack pulse is in cycle N+2.
//  SB/SH: ISSUE reads the word. MERGE (mem_read_data valid) drives
//   mem_write_en=1 at the same mem_addr. The data is the old word with the
//   selected lane replaced by wdata_q[7:0] or [15:0]. Write at edge N+2;
//   the ack pulse is in cycle N+3.
//  RESP->IDLE on the next edge; req_ready=1 again in the cycle after resp.
//  The core sees req_ready=0 from cycle N+1 until back in IDLE. A req held
//   during that time is accepted on return to IDLE.
//  mem_write_en is 1 only in ISSUE(SW) and MERGE. mem_addr holds the last
//   addr_q in other states. Stores with err never write.
// CONFIGURATION
//  LSU_BOUNDS_CHECK_EN defined: addr[31:2] >= MEM_WORDS is treated like
//   misalignment (resp_err=1 in cycle N+1, no mem access, rdata=0).
//  Not defined: no range check. mem_addr carries the full addr[31:2] and
//   data_mem's out-of-range behaviour applies.
// TESTING
//  mem[1]=32'h8877_6655; LB addr 0x5 -> rdata 32'h0000_0066, resp 3 cyc after accept
//  Same word; LH addr 0x6 -> 32'hFFFF_8877; LHU addr 0x6 -> 32'h0000_8877
//  SB addr 0x7 wdata 0xAB -> mem[1]=32'hAB77_6655, mem_write_en high 1 cycle only
//  LW addr 0x2 -> resp_err=1, rdata=0, next cycle; SH addr 0x1 -> no write
//  SW addr 0x8 wdata 32'hDEAD_BEEF then LW 0x8 back-to-back -> 32'hDEAD_BEEF
//  rst_n low during SB MERGE -> mem_write_en 0 at once, mem unchanged, IDLE
//  LSU_BOUNDS_CHECK_EN: LW addr 0x4000 (MEM_WORDS=4096) -> resp_err=1

Source files
------------

// File: rtl/load_store_unit.sv
// Byte-addressed RV32 load/store front end for a word-indexed, 1-cycle-read data memory.
// Optional range check enabled by defining LSU_BOUNDS_CHECK_EN.
module load_store_unit #(
   parameter int unsigned MEM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_write_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StMerge,
      StCapture,
      StResp
   } state_t;

   state_t      r_state;
   state_t      w_state_d;
   logic [31:0] r_addr;
   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_wdata;
   logic        r_resp_valid;
   logic [31:0] r_resp_rdata;
   logic        r_resp_err;

   logic        w_accept;
   logic        w_illegal;
   logic        w_misalign;
   logic        w_out_of_range;
   logic        w_req_err;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_merge_data;
   logic        w_store_word;

   assign req_ready = (r_state == StIdle);
   assign w_accept  = req_valid && req_ready;

   // Stores only support B/H/W; BU/HU and the three unused encodings are illegal.
   always_comb begin
      w_illegal = 1'b0;
      unique case (req_funct3)
         3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
         3'b100, 3'b101:         w_illegal = req_we;
         default:                w_illegal = 1'b1;
      endcase
   end

   assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_BOUNDS_CHECK_EN
   assign w_out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
`else
   logic w_unused_mem_words;
   assign w_unused_mem_words = (MEM_WORDS == 0);
   assign w_out_of_range     = 1'b0;
`endif

   assign w_req_err = w_illegal || w_misalign || w_out_of_range;

   // Little-endian lane selection of the returned word.
   always_comb begin
      w_byte = mem_read_data[7:0];
      unique case (r_addr[1:0])
         2'b00: w_byte = mem_read_data[7:0];
         2'b01: w_byte = mem_read_data[15:8];
         2'b10: w_byte = mem_read_data[23:16];
         2'b11: w_byte = mem_read_data[31:24];
         default: w_byte = mem_read_data[7:0];
      endcase
   end

   assign w_half = r_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];

   always_comb begin
      w_load_data = mem_read_data;
      unique case (r_funct3)
         3'b000: w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b100: w_load_data = {24'h000000, w_byte};
         3'b001: w_load_data = {{16{w_half[15]}}, w_half};
         3'b101: w_load_data = {16'h0000, w_half};
         default: w_load_data = mem_read_data;
      endcase
   end

   // Read-modify-write: old word with the addressed lane replaced by store data.
   always_comb begin
      w_merge_data = mem_read_data;
      if (r_funct3[1:0] == 2'b00) begin
         unique case (r_addr[1:0])
            2'b00: w_merge_data[7:0]   = r_wdata[7:0];
            2'b01: w_merge_data[15:8]  = r_wdata[7:0];
            2'b10: w_merge_data[23:16] = r_wdata[7:0];
            2'b11: w_merge_data[31:24] = r_wdata[7:0];
            default: w_merge_data      = mem_read_data;
         endcase
      end else if (r_addr[1]) begin
         w_merge_data[31:16] = r_wdata[15:0];
      end else begin
         w_merge_data[15:0] = r_wdata[15:0];
      end
   end

   assign w_store_word = r_we && (r_funct3 == 3'b010);

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_d = w_req_err ? StResp : StIssue;
            end
         end
         StIssue: begin
            if (!r_we) begin
               w_state_d = StCapture;
            end else if (w_store_word) begin
               w_state_d = StResp;
            end else begin
               w_state_d = StMerge;
            end
         end
         StMerge:   w_state_d = StResp;
         StCapture: w_state_d = StResp;
         StResp:    w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   // Decoded from state so the write strobe drops the instant reset asserts.
   always_comb begin
      mem_write_en   = 1'b0;
      mem_write_data = r_wdata;
      if ((r_state == StIssue) && w_store_word) begin
         mem_write_en = 1'b1;
      end else if (r_state == StMerge) begin
         mem_write_en   = 1'b1;
         mem_write_data = w_merge_data;
      end
   end

   assign mem_addr = {2'b00, r_addr[31:2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_addr       <= 32'h0;
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_wdata      <= 32'h0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_resp_valid <= (w_state_d == StResp);
         if (w_accept) begin
            r_addr       <= req_addr;
            r_we         <= req_we;
            r_funct3     <= req_funct3;
            r_wdata      <= req_wdata;
            r_resp_err   <= w_req_err;
            r_resp_rdata <= 32'h0;
         end else if (r_state == StCapture) begin
            r_resp_rdata <= w_load_data;
         end
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and checks data, error flag and arrival time.
module tb_load_store_unit;

   localparam int unsigned Depth = 4096;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_write_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   load_store_unit #(.MEM_WORDS(Depth)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_write_en   (mem_write_en),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // data_mem model: registered read, word-indexed.
   logic [31:0] mem [0:Depth-1];
   wire unused_addr_hi = ^mem_addr[31:12];
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_addr[11:0]] <= mem_write_data;
      mem_read_data <= mem[mem_addr[11:0]];
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      longint      t_exp;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   wr_cnt   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_write_en) wr_cnt++;
      if (resp_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_resp", {31'h0, resp_valid}, 64'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, "_rdata"}, {32'h0, resp_rdata}, {32'h0, e.rdata});
            chk({e.name, "_err"}, {63'h0, resp_err}, {63'h0, e.err});
            chk({e.name, "_time"}, $time, e.t_exp);
         end
      end
   end

   // Present a request at a negedge, wait (bounded) until accepted, record expectation.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input string nm, input bit push);
      int   n;
      exp_t e;
      @(negedge clk);
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         chk({nm, "_ready_timeout"}, {63'h0, req_ready}, 64'h1);
         req_valid = 1'b0;
      end else begin
         @(posedge clk);
         if (push) begin
            e.rdata = er;
            e.err   = ee;
            e.t_exp = $time + 5 + (lat - 1) * 10;
            e.name  = nm;
            q.push_back(e);
         end
      end
   endtask

   task automatic drain(input string nm);
      int n;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_drain"}, q.size(), 64'h0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < Depth; i++) mem[i] = 32'h0;
      mem[0] = 32'h1234_80FF;
      mem[1] = 32'h8877_6655;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {63'h0, req_ready}, 64'h1);
      chk("rst_resp_valid", {63'h0, resp_valid}, 64'h0);
      chk("rst_rdata", {32'h0, resp_rdata}, 64'h0);
      chk("rst_err", {63'h0, resp_err}, 64'h0);
      chk("rst_mem_we", {63'h0, mem_write_en}, 64'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      issue(1'b0, 3'b000, 32'h5, 32'h0, 32'h0000_0066, 1'b0, 3, "lb5", 1'b1);
      issue(1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF_8877, 1'b0, 3, "lh6", 1'b1);
      issue(1'b0, 3'b101, 32'h6, 32'h0, 32'h0000_8877, 1'b0, 3, "lhu6", 1'b1);
      issue(1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFF_FF88, 1'b0, 3, "lb7", 1'b1);
      issue(1'b0, 3'b100, 32'h7, 32'h0, 32'h0000_0088, 1'b0, 3, "lbu7", 1'b1);
      issue(1'b0, 3'b001, 32'h0, 32'h0, 32'hFFFF_80FF, 1'b0, 3, "lh0", 1'b1);
      issue(1'b0, 3'b100, 32'h1, 32'h0, 32'h0000_0080, 1'b0, 3, "lbu1", 1'b1);
      drain("loads");

      wr_cnt = 0;
      issue(1'b1, 3'b000, 32'h7, 32'h0000_00AB, 32'h0, 1'b0, 3, "sb7", 1'b1);
      drain("sb7");
      chk("sb7_mem", {32'h0, mem[1]}, {32'h0, 32'hAB77_6655});
      chk("sb7_wr_cycles", wr_cnt, 64'd1);

      wr_cnt = 0;
      issue(1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, 1, "lw2_mis", 1'b1);
      issue(1'b1, 3'b001, 32'h1, 32'h0000_CAFE, 32'h0, 1'b1, 1, "sh1_mis", 1'b1);
      issue(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, "ld_f011", 1'b1);
      issue(1'b1, 3'b100, 32'h4, 32'h0000_00FF, 32'h0, 1'b1, 1, "sbu_ill", 1'b1);
      drain("errs");
      chk("err_no_write", wr_cnt, 64'd0);
      chk("err_mem1", {32'h0, mem[1]}, {32'h0, 32'hAB77_6655});

      issue(1'b1, 3'b001, 32'h6, 32'h0000_1234, 32'h0, 1'b0, 3, "sh6", 1'b1);
      issue(1'b0, 3'b010, 32'h4, 32'h0, 32'h1234_6655, 1'b0, 3, "lw4", 1'b1);
      drain("sh6");

      issue(1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, "sw8", 1'b1);
      issue(1'b0, 3'b010, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, "lw8", 1'b1);
      drain("b2b");

`ifdef LSU_BOUNDS_CHECK_EN
      issue(1'b0, 3'b010, 32'h4000, 32'h0, 32'h0, 1'b1, 1, "lw_oob", 1'b1);
      drain("oob");
`endif

      // Reset while the SB is in its merge cycle: the write must never land.
      issue(1'b1, 3'b000, 32'h3, 32'h0000_0055, 32'h0, 1'b0, 3, "sb_rst", 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("merge_we_before_rst", {63'h0, mem_write_en}, 64'h1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_we", {63'h0, mem_write_en}, 64'h0);
      chk("rst_async_ready", {63'h0, req_ready}, 64'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_mem0", {32'h0, mem[0]}, {32'h0, 32'h1234_80FF});
      issue(1'b0, 3'b010, 32'h0, 32'h0, 32'h1234_80FF, 1'b0, 3, "lw0_after_rst", 1'b1);
      drain("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
